qdec_ctx_arb: RTL and testbench
===============================

// Module: qdec_ctx_arb
// PURPOSE
//  Arbitrates the single-port CABAC context memory between ctx-init, SAO and CQT requesters.
//  Reads serialize as read -> decoder -> state write-back, so no read ever sees a stale context.
//  Sits between the sub-FSMs and the context RAM / arith decoder inside the CABAC context FSM.
// PARAMETERS
//  NUM_REQ  3   requester count; index 0 = ctx-init (write only), 1 = SAO, 2 = CQT
//  ADDR_W   10  context memory address width
//  DATA_W   8   context word = {ctxState[6:0], mps}
// PORTS
//  clk        in   1                clock
//  rst        in   1                synchronous, active-high reset
//  flush      in   1                abandon in-flight transaction, return to IDLE
//  req_vld    in   NUM_REQ          request valid per requester
//  req_we     in   NUM_REQ          1 = write request, 0 = read request
//  req_addr   in   NUM_REQ*ADDR_W   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W   packed write data
//  req_rdy    out  NUM_REQ          one-hot grant, combinational, only in IDLE
//  rd_data    out  DATA_W           context word to arith decoder
//  rd_id      out  2                requester index owning rd_data
//  rd_vld     out  1                rd_data valid; held until rd_rdy
//  rd_rdy     in   1                arith decoder accepts context
//  upd_data   in   DATA_W           updated context from decoder
//  upd_vld    in   1                update valid
//  upd_rdy    out  1                update accepted; high only in UPD_WAIT
//  ctx_addr   out  ADDR_W           RAM address (registered)
//  ctx_wdata  out  DATA_W           RAM write data (registered)
//  ctx_we     out  1                RAM write enable (registered)
//  ctx_en     out  1                RAM enable (registered)
//  ctx_rdata  in   DATA_W           RAM read data, 1-cycle latency after ctx_en
//  busy       out  1                state != IDLE
//  err_pulse  out  1                1-cycle pulse on upd_vld outside UPD_WAIT
// BEHAVIOUR
//  - Reset / flush: state = IDLE; all outputs 0 (req_rdy = 0 during rst). Latched address is cleared.
//  - States: IDLE -> RD_ISSUE -> RD_WAIT -> RD_OUT -> UPD_WAIT -> IDLE.
//  - IDLE: grant one requester with req_vld.
//    - Write grant (cycle T): ctx_en = ctx_we = 1 with addr/wdata at T+1; state stays IDLE.
//    - Read grant (cycle T): latch addr and id; ctx_en = 1, ctx_we = 0 at T+1 (RD_ISSUE).
//      ctx_rdata is sampled at T+2 (RD_WAIT); rd_vld = 1 from T+3 (RD_OUT).
//  - RD_OUT: hold rd_data/rd_id/rd_vld stable until rd_vld & rd_rdy, then go to UPD_WAIT and clear rd_vld.
//  - UPD_WAIT: upd_rdy = 1. On upd_vld (cycle U): write upd_data to the latched addr at U+1
//    (ctx_en = ctx_we = 1) and return to IDLE at U+1. The earliest next grant is U+1, so its RAM access lands at U+2.
//  - upd_vld outside UPD_WAIT: ignored, no RAM write, err_pulse = 1 next cycle.
//  - Requester 0 asserting req_we = 0: treated as a write of req_wdata (init is write only).
//  - flush wins over every other event in the same cycle. A write already registered to RAM completes.
//  - Grant is not retracted. A requester dropping req_vld in its grant cycle still counts as granted.
// CONFIGURATION
//  QDEC_CTX_ARB_RR_EN defined: round-robin among requesters 1..NUM_REQ-1.
//    The pointer advances past the last granted index; requester 0 still has absolute priority.
//  Not defined: fixed priority, lowest index wins.
// STRUCTURE
//  - qdec_cabac_package gains t_state_ctx_arb (IDLE, RD_ISSUE, RD_WAIT, RD_OUT, UPD_WAIT) and localparams
//    CTX_ADDR_W = 10, CTX_DATA_W = 8, CTX_REQ_INIT = 0, CTX_REQ_SAO = 1, CTX_REQ_CQT = 2.
//  - One sub-module, qdec_ctx_arb_pick: combinational grant picker holding the RR pointer register.
//    It is instantiated once and contains the ifdef.
// TESTING
//  1. Init burst: req0 writes addr 0..3 with data 8'h10..8'h13 on back-to-back cycles
//     -> ctx_we = 1 on 4 consecutive cycles, addrs 0..3; busy stays 0.
//  2. SAO read of addr 10'h05 (RAM holds 8'hA6), rd_rdy = 1, then upd 8'hA8
//     -> rd_vld at T+3 with rd_data = 8'hA6, rd_id = 1; RAM addr 5 = 8'hA8 at U+1.
//  3. SAO and CQT both request in IDLE: fixed priority -> SAO granted, CQT waits until the SAO update;
//     RR_EN -> second simultaneous pair grants CQT.
//  4. Back-pressure: rd_rdy = 0 for 5 cycles -> rd_vld and rd_data stable; upd_rdy = 0; no RAM access.
//  5. upd_vld in IDLE -> err_pulse for 1 cycle, ctx_we stays 0.
//  6. flush in RD_WAIT -> IDLE next cycle, rd_vld never asserts; new req0 write is granted the cycle after.

Source files
------------

// File: rtl/qdec_cabac_package.sv
// Shared types and constants for the CABAC context path.
// Holds the context-arbiter state encoding and the requester index map.
package qdec_cabac_package;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT,
    UPD_WAIT
  } t_state_ctx_arb;

  localparam int CTX_ADDR_W   = 10;
  localparam int CTX_DATA_W   = 8;
  localparam int CTX_REQ_INIT = 0;
  localparam int CTX_REQ_SAO  = 1;
  localparam int CTX_REQ_CQT  = 2;
  localparam int CTX_ID_W     = 2;

endpackage

// File: rtl/qdec_ctx_arb_pick.sv
// Combinational grant picker for the context-memory arbiter.
// QDEC_CTX_ARB_RR_EN selects round-robin among requesters 1..NUM_REQ-1; otherwise lowest index wins.
module qdec_ctx_arb_pick
  import qdec_cabac_package::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_REQ-1:0]  req_vld,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                gnt_any,
  output logic [CTX_ID_W-1:0] gnt_idx,
  output logic [CTX_ID_W-1:0] last_idx
);

  // Last granted non-init requester: the RR pointer and the owner id of a pending read.
  logic [CTX_ID_W-1:0] last_q, last_d;
  logic [CTX_ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (en) begin
      if (req_vld[CTX_REQ_INIT]) begin
        gnt_any = 1'b1;
        gnt_idx = CTX_ID_W'(CTX_REQ_INIT);
      end else begin
        for (int k = 1; k < NUM_REQ; k++) begin
`ifdef QDEC_CTX_ARB_RR_EN
          cand = CTX_ID_W'(((int'(last_q) - 1 + k) % (NUM_REQ - 1)) + 1);
`else
          cand = CTX_ID_W'(k);
`endif
          if (!gnt_any && req_vld[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    last_d = last_q;
    if (gnt_any && (gnt_idx != CTX_ID_W'(CTX_REQ_INIT))) last_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= CTX_ID_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end

  assign last_idx = last_q;

endmodule

// File: rtl/qdec_ctx_arb.sv
// Single-port CABAC context memory arbiter: serializes read -> decode -> write-back per context.
// Grant policy is chosen in qdec_ctx_arb_pick via QDEC_CTX_ARB_RR_EN.
module qdec_ctx_arb
  import qdec_cabac_package::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = CTX_ADDR_W,
  parameter int DATA_W  = CTX_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [DATA_W-1:0]         rd_data,
  output logic [1:0]                rd_id,
  output logic                      rd_vld,
  input  logic                      rd_rdy,
  input  logic [DATA_W-1:0]         upd_data,
  input  logic                      upd_vld,
  output logic                      upd_rdy,
  output logic [ADDR_W-1:0]         ctx_addr,
  output logic [DATA_W-1:0]         ctx_wdata,
  output logic                      ctx_we,
  output logic                      ctx_en,
  input  logic [DATA_W-1:0]         ctx_rdata,
  output logic                      busy,
  output logic                      err_pulse
);

  t_state_ctx_arb      state_q, state_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d, ctx_addr_q, ctx_addr_d;
  logic [DATA_W-1:0]   ctx_wdata_q, ctx_wdata_d, rd_data_q, rd_data_d;
  logic                ctx_we_q, ctx_we_d, ctx_en_q, ctx_en_d;
  logic                rd_vld_q, rd_vld_d, upd_rdy_q, upd_rdy_d;
  logic                busy_q, busy_d, err_q, err_d;
  logic [CTX_ID_W-1:0] rd_id_q, rd_id_d;

  logic                pick_en, gnt_any, gnt_is_wr;
  logic [CTX_ID_W-1:0] gnt_idx, last_idx;
  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  assign pick_en = (state_q == IDLE) && !rst && !flush;

  qdec_ctx_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .en       (pick_en),
    .req_vld  (req_vld),
    .gnt      (req_rdy),
    .gnt_any  (gnt_any),
    .gnt_idx  (gnt_idx),
    .last_idx (last_idx)
  );

  // Init is write-only, so its req_we is ignored.
  assign gnt_is_wr = (gnt_idx == CTX_ID_W'(CTX_REQ_INIT)) || req_we[gnt_idx];

  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    ctx_addr_d  = ctx_addr_q;
    ctx_wdata_d = ctx_wdata_q;
    ctx_we_d    = 1'b0;
    ctx_en_d    = 1'b0;
    rd_vld_d    = rd_vld_q;
    rd_data_d   = rd_data_q;
    rd_id_d     = rd_id_q;
    err_d       = upd_vld && (state_q != UPD_WAIT);
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = addr_arr[gnt_idx];
          if (gnt_is_wr) begin
            ctx_we_d    = 1'b1;
            ctx_wdata_d = wdata_arr[gnt_idx];
          end else begin
            lat_addr_d = addr_arr[gnt_idx];
            state_d    = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rd_data_d = ctx_rdata;
        rd_id_d   = last_idx;
        rd_vld_d  = 1'b1;
        state_d   = RD_OUT;
      end
      RD_OUT: begin
        if (rd_rdy) begin
          rd_vld_d = 1'b0;
          state_d  = UPD_WAIT;
        end
      end
      UPD_WAIT: begin
        if (upd_vld) begin
          ctx_en_d    = 1'b1;
          ctx_we_d    = 1'b1;
          ctx_addr_d  = lat_addr_q;
          ctx_wdata_d = upd_data;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The RAM write issued last cycle has already been presented, so clearing here cannot cut it short.
    if (flush) begin
      state_d     = IDLE;
      lat_addr_d  = '0;
      ctx_addr_d  = '0;
      ctx_wdata_d = '0;
      ctx_we_d    = 1'b0;
      ctx_en_d    = 1'b0;
      rd_vld_d    = 1'b0;
      rd_data_d   = '0;
      rd_id_d     = '0;
      err_d       = 1'b0;
    end
    upd_rdy_d = (state_d == UPD_WAIT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_addr_q  <= '0;
      ctx_addr_q  <= '0;
      ctx_wdata_q <= '0;
      ctx_we_q    <= 1'b0;
      ctx_en_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_id_q     <= '0;
      upd_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      ctx_addr_q  <= ctx_addr_d;
      ctx_wdata_q <= ctx_wdata_d;
      ctx_we_q    <= ctx_we_d;
      ctx_en_q    <= ctx_en_d;
      rd_vld_q    <= rd_vld_d;
      rd_data_q   <= rd_data_d;
      rd_id_q     <= rd_id_d;
      upd_rdy_q   <= upd_rdy_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign ctx_addr  = ctx_addr_q;
  assign ctx_wdata = ctx_wdata_q;
  assign ctx_we    = ctx_we_q;
  assign ctx_en    = ctx_en_q;
  assign rd_vld    = rd_vld_q;
  assign rd_data   = rd_data_q;
  assign rd_id     = rd_id_q;
  assign upd_rdy   = upd_rdy_q;
  assign busy      = busy_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_qdec_ctx_arb.sv
// Bench for qdec_ctx_arb: behavioural context RAM plus a transaction-level reference model.
// Define QDEC_CTX_ARB_RR_EN for both bench and RTL to exercise the round-robin build.
module tb_qdec_ctx_arb;
  import qdec_cabac_package::*;

  localparam int NR = 3;
  localparam int AW = CTX_ADDR_W;
  localparam int DW = CTX_DATA_W;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [NR-1:0]   req_vld, req_we, req_rdy;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]   rd_data, upd_data, ctx_wdata, ctx_rdata;
  logic [1:0]      rd_id;
  logic            rd_vld, rd_rdy, upd_vld, upd_rdy, ctx_we, ctx_en, busy, err_pulse;
  logic [AW-1:0]   ctx_addr;

  qdec_ctx_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_vld(req_vld), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdy(req_rdy),
    .rd_data(rd_data), .rd_id(rd_id), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
    .upd_data(upd_data), .upd_vld(upd_vld), .upd_rdy(upd_rdy),
    .ctx_addr(ctx_addr), .ctx_wdata(ctx_wdata), .ctx_we(ctx_we), .ctx_en(ctx_en),
    .ctx_rdata(ctx_rdata),
    .busy(busy), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural single-port context RAM with one cycle of read latency.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic          init_ram;
  logic [DW-1:0] ram_seed;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 29) ^ ram_seed;
  endfunction

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= init_val(i);
    end else if (ctx_en) begin
      if (ctx_we) ram[ctx_addr] <= ctx_wdata;
      else        ctx_rdata     <= ram[ctx_addr];
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: round-robin memory and the read currently outstanding.
  int            rr_last;
  logic [AW-1:0] rd_addr_m;
  int            rd_id_m;

  function automatic int model_pick(input logic [NR-1:0] vld);
    int order[$];
    if (vld[0]) return 0;
`ifdef QDEC_CTX_ARB_RR_EN
    for (int c = rr_last + 1; c < NR; c++) order.push_back(c);
    for (int c = 1; c <= rr_last; c++)     order.push_back(c);
`else
    for (int c = 1; c < NR; c++) order.push_back(c);
`endif
    foreach (order[i]) if (vld[order[i]]) return order[i];
    return -1;
  endfunction

  // One IDLE arbitration cycle; the winner carries wa/wd, other slots get random values.
  task automatic arb_cycle(input logic [NR-1:0] vld, input logic [NR-1:0] we,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd, output int win);
    win = model_pick(vld);
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = AW'($urandom);
      req_wdata[i*DW +: DW] = DW'($urandom);
    end
    if (win >= 0) begin
      req_addr[win*AW +: AW]  = wa;
      req_wdata[win*DW +: DW] = wd;
    end
    req_vld = vld;
    req_we  = we;
    #1;
    check("req_rdy", 32'(req_rdy), (win < 0) ? 32'd0 : (32'd1 << win));
    if (win >= 1) rr_last = win;
    step();
    req_vld = '0;
    req_we  = '0;
    if (win < 0) return;
    check("ctx_en", 32'(ctx_en), 32'd1);
    check("ctx_addr", 32'(ctx_addr), 32'(wa));
    if (win == 0 || we[win]) begin
      check("wr_we", 32'(ctx_we), 32'd1);
      check("wr_data", 32'(ctx_wdata), 32'(wd));
      check("wr_busy", 32'(busy), 32'd0);
      exp_mem[wa] = wd;
      $display("wr   id=%0d addr=0x%03h data=0x%02h", win, wa, wd);
    end else begin
      check("rd_we", 32'(ctx_we), 32'd0);
      check("rd_busy", 32'(busy), 32'd1);
      rd_addr_m = wa;
      rd_id_m   = win;
    end
  endtask

  // Continues a read from the cycle after its grant through the write-back.
  task automatic read_tail(input int bp, input int dly, input logic [DW-1:0] ud);
    logic [DW-1:0] exp_d;
    exp_d = exp_mem[rd_addr_m];
    step();
    check("rdwait_vld", 32'(rd_vld), 32'd0);
    check("rdwait_en", 32'(ctx_en), 32'd0);
    step();
    check("rd_vld", 32'(rd_vld), 32'd1);
    check("rd_data", 32'(rd_data), 32'(exp_d));
    check("rd_id", 32'(rd_id), 32'(rd_id_m));
    check("rdout_upd_rdy", 32'(upd_rdy), 32'd0);
    rd_rdy = 1'b0;
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_vld", 32'(rd_vld), 32'd1);
      check("bp_data", 32'(rd_data), 32'(exp_d));
      check("bp_upd_rdy", 32'(upd_rdy), 32'd0);
      check("bp_en", 32'(ctx_en), 32'd0);
    end
    rd_rdy = 1'b1;
    step();
    rd_rdy = 1'b0;
    check("acc_vld", 32'(rd_vld), 32'd0);
    check("acc_upd_rdy", 32'(upd_rdy), 32'd1);
    for (int i = 0; i < dly; i++) begin
      step();
      check("wait_upd_rdy", 32'(upd_rdy), 32'd1);
      check("wait_en", 32'(ctx_en), 32'd0);
    end
    upd_vld  = 1'b1;
    upd_data = ud;
    step();
    upd_vld = 1'b0;
    check("upd_en", 32'(ctx_en), 32'd1);
    check("upd_we", 32'(ctx_we), 32'd1);
    check("upd_addr", 32'(ctx_addr), 32'(rd_addr_m));
    check("upd_data", 32'(ctx_wdata), 32'(ud));
    check("upd_busy", 32'(busy), 32'd0);
    check("upd_rdy_off", 32'(upd_rdy), 32'd0);
    exp_mem[rd_addr_m] = ud;
    $display("rd   id=%0d addr=0x%03h data=0x%02h bp=%0d upd=0x%02h", rd_id_m, rd_addr_m, exp_d, bp, ud);
  endtask

  initial begin
    int win;
    logic [NR-1:0] v, w;
    rst = 1'b1; flush = 1'b0; rd_rdy = 1'b0; upd_vld = 1'b0; upd_data = '0;
    req_vld = '1; req_we = '0; req_addr = '0; req_wdata = '0;
    ram_seed = DW'($urandom);
    init_ram = 1'b1;
    rr_last  = NR - 1;
    for (int i = 0; i < (1<<AW); i++) exp_mem[i] = init_val(i);

    // Reset: no grant even with every requester pending, all outputs low.
    step();
    step();
    #1;
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_ctx_en", 32'(ctx_en), 32'd0);
    check("rst_upd_rdy", 32'(upd_rdy), 32'd0);
    check("rst_err", 32'(err_pulse), 32'd0);
    req_vld = '0; rst = 1'b0; init_ram = 1'b0;
    step();

    // Init burst on back-to-back cycles, alternating req_we on requester 0.
    for (int i = 0; i < 4; i++) begin
      w = NR'(i & 1);
      arb_cycle(3'b001, w, AW'(i), DW'(8'h10 + i), win);
    end
    step();

    // SAO read of a freshly initialised context, then write-back.
    arb_cycle(3'b001, 3'b000, 10'h005, 8'hA6, win);
    arb_cycle(3'b010, 3'b000, 10'h005, 8'h00, win);
    read_tail(0, 0, 8'hA8);
    step();
    check("ram5", 32'(ram[5]), 32'h0A8);

    // Simultaneous SAO/CQT pairs; the loser is re-presented after the write-back.
    for (int p = 0; p < 2; p++) begin
      arb_cycle(3'b110, 3'b000, AW'($urandom), 8'h00, win);
      read_tail(1, 0, DW'($urandom));
      v = (win == 1) ? 3'b100 : 3'b010;
      arb_cycle(v, 3'b000, AW'($urandom), 8'h00, win);
      read_tail(0, 1, DW'($urandom));
    end

    // Long back-pressure on the decoder side.
    arb_cycle(3'b010, 3'b000, 10'h123, 8'h00, win);
    read_tail(5, 2, 8'h5C);

    // Update with nobody waiting for it.
    upd_vld = 1'b1; upd_data = 8'hEE;
    step();
    upd_vld = 1'b0;
    check("err_pulse", 32'(err_pulse), 32'd1);
    check("err_no_we", 32'(ctx_we), 32'd0);
    check("err_no_en", 32'(ctx_en), 32'd0);
    step();
    check("err_clear", 32'(err_pulse), 32'd0);
    $display("err  upd_vld in IDLE");

    // Flush while the read is in RD_WAIT.
    arb_cycle(3'b100, 3'b000, 10'h2AB, 8'h00, win);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_rd_vld", 32'(rd_vld), 32'd0);
    check("flush_upd_rdy", 32'(upd_rdy), 32'd0);
    arb_cycle(3'b001, 3'b000, 10'h2AC, 8'h77, win);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_flush_rd_vld", 32'(rd_vld), 32'd0);
    end
    $display("flush during RD_WAIT");

    // Randomised mix of reads and writes from all requesters.
    for (int n = 0; n < 40; n++) begin
      v = NR'($urandom_range(1, 7));
      w = NR'($urandom);
      arb_cycle(v, w, AW'($urandom), DW'($urandom), win);
      if (!(win == 0 || w[win]))
        read_tail(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    for (int i = 0; i < 8; i++) begin
      int a;
      a = int'($urandom_range(0, (1<<AW) - 1));
      check("ram_final", 32'(ram[a]), 32'(exp_mem[a]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
